pcie_tx_st_source: RTL and testbench

Transmit-side Avalon-ST source for the Cyclone 10 / Arria 10 PCIe hard IP. It accepts 64-bit TLP beats from the RIFFA engine over a valid/ready interface and buffers them in a small FIFO. It drives tx_st_sop/eop/valid/data into the HIP and honours the HIP's tx_st_ready latency, so RIFFA never has to model that latency itself. It sits between the RIFFA TX engine and the PCIe HIP wrapper, in the pld_clk domain.

---
 rtl/pcie_tx_pkg.sv | 16 +
 rtl/pcie_tx_fifo.sv | 74 +++++++
 rtl/pcie_tx_st_source.sv | 189 ++++++++++++++++++
 tb/tb_pcie_tx_st_source.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tx_pkg.sv
// Shared types and constants for the PCIe TX Avalon-ST source.
// Contents: tx_beat_t (sop, eop, 64-bit data), TX_DATA_W, TX_RL_MAX.
// Imported by pcie_tx_fifo and pcie_tx_st_source.
package pcie_tx_pkg;

    localparam int TX_DATA_W = 64;
    localparam int TX_RL_MAX = 3;

    // One TLP beat as it travels through the buffer: 66 bits.
    typedef struct packed {
        logic                 sop;
        logic                 eop;
        logic [TX_DATA_W-1:0] data;
    } tx_beat_t;

endpackage

// File: rtl/pcie_tx_fifo.sv
// Synchronous first-word-fall-through FIFO of tx_beat_t beats.
// Ports: clk_i/rst_i (async active-high), push_i/push_dat_i, pop_i,
//        head_o (current head, valid when !empty_o), count_o, full_o, empty_o.
// Push while full and pop while empty are ignored.
module pcie_tx_fifo
    import pcie_tx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  tx_beat_t               push_dat_i,
    input  logic                   pop_i,
    output tx_beat_t               head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    tx_beat_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; contents are only read when count says valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/pcie_tx_st_source.sv
// TX Avalon-ST source: buffers RIFFA TLP beats and launches them to the PCIe
// HIP honouring its tx_st_ready latency (READY_LATENCY, 1..3), with a sticky
// framing-error flag and a launched-TLP counter.
// Ports: pld_clk, reset_status (async active-high), in_* (valid/ready upstream),
//        tx_st_* (to HIP), proto_err, tx_pkt_cnt.
// Build option PCIE_TX_STORE_FORWARD_EN: hold a sop beat until its whole TLP
// is buffered (store-and-forward); undefined gives cut-through.
module pcie_tx_st_source
    import pcie_tx_pkg::*;
#(
    parameter int READY_LATENCY = 2,
    parameter int DEPTH         = 16
) (
    input  logic                 pld_clk,
    input  logic                 reset_status,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic [TX_DATA_W-1:0] in_data,
    input  logic                 tx_st_ready,
    output logic                 tx_st_valid,
    output logic                 tx_st_sop,
    output logic                 tx_st_eop,
    output logic [TX_DATA_W-1:0] tx_st_data,
    output logic                 proto_err,
    output logic [15:0]          tx_pkt_cnt
);

    localparam int CW     = $clog2(DEPTH) + 1;
    // Only the ready-pipe stages that feed the launch decision are kept.
    localparam int PIPE_W = (READY_LATENCY >= 2) ? READY_LATENCY - 1 : 1;

    generate
        if (READY_LATENCY < 1 || READY_LATENCY > TX_RL_MAX) begin : g_bad_rl
            $error("pcie_tx_st_source: READY_LATENCY must be 1..3");
        end
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("pcie_tx_st_source: DEPTH must be a power of two >= 4");
        end
    endgenerate

    tx_beat_t               in_beat;
    tx_beat_t               head;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   perm;
    logic                   launch_ok;
    logic                   forced_launch;
    logic                   frame_err;

    logic [PIPE_W-1:0]      rdy_q, rdy_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   tx_sop_q, tx_sop_d;
    logic                   tx_eop_q, tx_eop_d;
    logic [TX_DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                   in_pkt_q, in_pkt_d;
    logic                   proto_err_q, proto_err_d;
    logic [15:0]            pkt_cnt_q, pkt_cnt_d;

    assign in_beat  = '{sop: in_sop, eop: in_eop, data: in_data};
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    pcie_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (pld_clk),
        .rst_i      (reset_status),
        .push_i     (push),
        .push_dat_i (in_beat),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Launch permission: a beat loaded on the edge after perm appears on
    // tx_st exactly READY_LATENCY cycles after the ready cycle it answers.
    generate
        if (READY_LATENCY >= 2) begin : g_perm_pipe
            assign perm = rdy_q[PIPE_W-1];
        end else begin : g_perm_direct
            assign perm = tx_st_ready;
        end
    endgenerate

    always_comb begin
        rdy_d    = '0;
        rdy_d[0] = tx_st_ready;
        for (int i = 1; i < PIPE_W; i++) begin
            rdy_d[i] = rdy_q[i-1];
        end
    end

`ifdef PCIE_TX_STORE_FORWARD_EN
    // Number of complete TLPs (eop beats) currently buffered.
    logic [CW-1:0] eop_cnt_q, eop_cnt_d;

    always_comb begin
        eop_cnt_d = eop_cnt_q;
        if ((push && in_eop) && !(pop && head.eop)) begin
            eop_cnt_d = eop_cnt_q + 1'b1;
        end else if (!(push && in_eop) && (pop && head.eop)) begin
            eop_cnt_d = eop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge pld_clk or posedge reset_status) begin
        if (reset_status) begin
            eop_cnt_q <= '0;
        end else begin
            eop_cnt_q <= eop_cnt_d;
        end
    end

    // A sop waits for a whole TLP, except when the buffer is full with no
    // eop in it: nothing more can arrive, so launch anyway and flag it.
    assign launch_ok     = !head.sop || (eop_cnt_q != '0) || fifo_full;
    assign forced_launch = pop && head.sop && (eop_cnt_q == '0);
`else
    assign launch_ok     = 1'b1;
    assign forced_launch = 1'b0;
`endif

    assign pop = perm && !fifo_empty && launch_ok;

    // Framing: sop inside a packet, or a continuation beat outside one.
    assign frame_err = push && (in_sop ? in_pkt_q : !in_pkt_q);

    always_comb begin
        tx_valid_d  = pop;
        tx_sop_d    = tx_sop_q;
        tx_eop_d    = tx_eop_q;
        tx_data_d   = tx_data_q;
        in_pkt_d    = in_pkt_q;
        proto_err_d = proto_err_q | frame_err | forced_launch;
        pkt_cnt_d   = pkt_cnt_q;
        if (pop) begin
            tx_sop_d  = head.sop;
            tx_eop_d  = head.eop;
            tx_data_d = head.data;
            if (head.eop) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
        end
        if (push) begin
            if (in_eop) begin
                in_pkt_d = 1'b0;
            end else if (in_sop) begin
                in_pkt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pld_clk or posedge reset_status) begin
        if (reset_status) begin
            rdy_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_sop_q    <= 1'b0;
            tx_eop_q    <= 1'b0;
            tx_data_q   <= '0;
            in_pkt_q    <= 1'b0;
            proto_err_q <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            rdy_q       <= rdy_d;
            tx_valid_q  <= tx_valid_d;
            tx_sop_q    <= tx_sop_d;
            tx_eop_q    <= tx_eop_d;
            tx_data_q   <= tx_data_d;
            in_pkt_q    <= in_pkt_d;
            proto_err_q <= proto_err_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign tx_st_valid = tx_valid_q;
    assign tx_st_sop   = tx_sop_q;
    assign tx_st_eop   = tx_eop_q;
    assign tx_st_data  = tx_data_q;
    assign proto_err   = proto_err_q;
    assign tx_pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_pcie_tx_st_source.sv
// Testbench for pcie_tx_st_source: scoreboard of accepted beats, a monitor
// that checks every launched beat, and directed plus randomized stimulus.
module tb_pcie_tx_st_source;
    import pcie_tx_pkg::*;

    localparam int RL    = 2;
    localparam int DEPTH = 16;

    logic        pld_clk = 1'b0;
    logic        reset_status = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [63:0] in_data = '0;
    logic        tx_st_ready = 1'b0;
    logic        tx_st_valid;
    logic        tx_st_sop;
    logic        tx_st_eop;
    logic [63:0] tx_st_data;
    logic        proto_err;
    logic [15:0] tx_pkt_cnt;

    pcie_tx_st_source #(.READY_LATENCY(RL), .DEPTH(DEPTH)) dut (
        .pld_clk      (pld_clk),
        .reset_status (reset_status),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .in_data      (in_data),
        .tx_st_ready  (tx_st_ready),
        .tx_st_valid  (tx_st_valid),
        .tx_st_sop    (tx_st_sop),
        .tx_st_eop    (tx_st_eop),
        .tx_st_data   (tx_st_data),
        .proto_err    (proto_err),
        .tx_pkt_cnt   (tx_pkt_cnt)
    );

    always #5 pld_clk = ~pld_clk;

    typedef struct {
        logic        sop;
        logic        eop;
        logic [63:0] data;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   acc_log[$];
    int   out_log[$];
    bit   rdy_hist[int];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   rdy_mode = 1;   // 0 low, 1 high, 2 random, 3 alternate
    logic m_in_pkt = 1'b0;
    logic m_err = 1'b0;
    int   m_pkt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(posedge pld_clk) cyc <= cyc + 1;

    // HIP ready pattern generator.
    always @(posedge pld_clk) begin
        #1;
        case (rdy_mode)
            0:       tx_st_ready = 1'b0;
            1:       tx_st_ready = 1'b1;
            2:       tx_st_ready = ($urandom_range(0, 3) != 0);
            default: tx_st_ready = (cyc % 2 == 0);
        endcase
    end

    // Reference model reset: buffered beats, framing state and counter are lost.
    always @(posedge reset_status) begin
        exp_q.delete();
        m_in_pkt = 1'b0;
        m_err    = 1'b0;
        m_pkt    = 0;
    end

    // Input side: record accepted beats and track framing at TLP level.
    always @(negedge pld_clk) begin
        rdy_hist[cyc] = tx_st_ready;
        if (!reset_status) begin
            chk("proto_err", proto_err, m_err);
            if (in_valid && in_ready) begin
                exp_q.push_back('{sop: in_sop, eop: in_eop, data: in_data, acc: cyc});
                acc_log.push_back(cyc);
                if (in_sop ? m_in_pkt : !m_in_pkt) m_err = 1'b1;
                if (in_eop) m_in_pkt = 1'b0;
                else if (in_sop) m_in_pkt = 1'b1;
            end
        end
    end

    // Output side: every launched beat must be the oldest outstanding one.
    always @(negedge pld_clk) begin
        exp_t e;
        if (!reset_status && tx_st_valid) begin
            out_log.push_back(cyc);
            if (cyc >= RL) chk("ready_latency", rdy_hist[cyc-RL], 1);
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("data", tx_st_data, e.data);
                chk("sop", tx_st_sop, e.sop);
                chk("eop", tx_st_eop, e.eop);
                chk("min_latency", cyc >= e.acc + 2, 1);
                if (e.eop) m_pkt = (m_pkt + 1) % 65536;
                chk("tx_pkt_cnt", tx_pkt_cnt, m_pkt);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge pld_clk);
            #1;
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic s, input logic e, input logic [63:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_sop   = s;
        in_eop   = e;
        in_data  = d;
        forever begin
            @(negedge pld_clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge pld_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rdy_mode = 1;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge pld_clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        step(RL + 2);
    endtask

    initial begin
        int base;
        int t;
        int len;

        // Reset state
        #1;
        chk("rst_valid", tx_st_valid, 0);
        chk("rst_sop", tx_st_sop, 0);
        chk("rst_eop", tx_st_eop, 0);
        chk("rst_data", tx_st_data, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_pkt_cnt", tx_pkt_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        step(3);
        reset_status = 1'b0;
        step(5);

        // 4-beat TLP with ready high: back-to-back launch
        acc_log.delete();
        out_log.delete();
        send(1, 0, 64'h1);
        send(0, 0, 64'h2);
        send(0, 0, 64'h3);
        send(0, 1, 64'h4);
        step(8);
`ifdef PCIE_TX_STORE_FORWARD_EN
        base = acc_log[3] + 2;
`else
        base = acc_log[0] + 2;
`endif
        chk("t1_beats", out_log.size(), 4);
        for (int i = 0; i < 4 && i < out_log.size(); i++)
            chk("t1_cycle", out_log[i], base + i);
        chk("t1_pkt_cnt", tx_pkt_cnt, 1);

        // 6-beat TLP with alternating ready
        out_log.delete();
        rdy_mode = 3;
        for (int i = 0; i < 6; i++) send(i == 0, i == 5, 64'h10 + i);
        drain();
        chk("t2_beats", out_log.size(), 6);

        // Fill with ready low, 17th beat stalls, then release
        rdy_mode = 0;
        step(RL + 3);
        out_log.delete();
        for (int i = 0; i < 16; i++) send(i % 4 == 0, i % 4 == 3, 64'h100 + i);
        @(negedge pld_clk);
        chk("t3_full", in_ready, 0);
        @(posedge pld_clk);
        #1;
        in_valid = 1'b1;
        in_sop   = 1'b1;
        in_eop   = 1'b1;
        in_data  = 64'h200;
        for (int i = 0; i < 3; i++) begin
            @(negedge pld_clk);
            chk("t3_stall", in_ready, 0);
        end
        @(posedge pld_clk);
        #1;
        rdy_mode = 1;
        t = 0;
        do begin
            @(negedge pld_clk);
            t++;
        end while (!tx_st_ready && t < 5);
        chk("t3_ready_seen", tx_st_ready, 1);
        @(negedge pld_clk);
        chk("t3_in_ready_pop", in_ready, 0);
        @(negedge pld_clk);
        chk("t3_in_ready_back", in_ready, 1);
        @(posedge pld_clk);
        #1;
        in_valid = 1'b0;
        drain();
        chk("t3_beats", out_log.size(), 17);

        // sop held back (store-forward) or launched immediately (cut-through)
        acc_log.delete();
        out_log.delete();
        send(1, 0, 64'h30);
        step(10);
        send(0, 1, 64'h31);
        step(6);
        chk("t4_beats", out_log.size(), 2);
`ifdef PCIE_TX_STORE_FORWARD_EN
        if (out_log.size() > 0) chk("t4_sop_cycle", out_log[0], acc_log[1] + 2);
`else
        if (out_log.size() > 0) chk("t4_sop_cycle", out_log[0], acc_log[0] + 2);
`endif

        // Double sop: sticky framing error, beats still forwarded
        send(1, 0, 64'h40);
        send(1, 0, 64'h41);
        send(0, 1, 64'h42);
        step(5);
        chk("t5_proto_err", proto_err, 1);
        step(5);
        chk("t5_proto_sticky", proto_err, 1);
        drain();

        // Reset mid-TLP
        send(1, 0, 64'h50);
        send(0, 0, 64'h51);
        reset_status = 1'b1;
        #1;
        chk("t6_valid", tx_st_valid, 0);
        chk("t6_in_ready", in_ready, 1);
        chk("t6_proto_err", proto_err, 0);
        chk("t6_pkt_cnt", tx_pkt_cnt, 0);
        step(3);
        reset_status = 1'b0;
        step(RL + 3);
        send(1, 1, 64'h60);
        step(6);
        chk("t6_pkt_after", tx_pkt_cnt, 1);

        // Randomized legal traffic with random ready
        rdy_mode = 2;
        for (int p = 0; p < 12; p++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                send(i == 0, i == len - 1, {$urandom, $urandom});
                step($urandom_range(0, 1));
            end
            step($urandom_range(0, 3));
        end
        drain();
        chk("final_proto_err", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
